// File: rtl/iiitb_3bit_rc_mon_if.sv
// Bus between a 3-bit ring counter source and its integrity monitor.
// The master drives the counter-side inputs. The monitor (slave) returns status.
interface iiitb_3bit_rc_mon_if;
    logic       enable;
    logic [2:0] count_in;
    logic       clear_err;
    logic [1:0] phase;
    logic       locked;
    logic       fault;
    logic [7:0] rev_count;
    logic [3:0] err_count;
    logic       rev_pulse;

    modport master (
        output enable, count_in, clear_err,
        input  phase, locked, fault, rev_count, err_count, rev_pulse
    );
    modport slave (
        input  enable, count_in, clear_err,
        output phase, locked, fault, rev_count, err_count, rev_pulse
    );
endinterface

// File: rtl/iiitb_3bit_rc_mon.sv
// Monitor for a 3-bit ring counter: checks step legality, locks after SYNC_LEN
// good samples, counts revolutions and errors, and latches a sticky fault.
module iiitb_3bit_rc_mon #(
    parameter int SYNC_LEN = 3
) (
    input logic               clk,
    input logic               rst_n,
    iiitb_3bit_rc_mon_if.slave bus
);
    typedef enum logic [1:0] {UNLOCK, SYNC, LOCKED, FAULT} state_t;

    state_t     state, state_nxt;
    logic [2:0] good_cnt, good_nxt;
    logic [3:0] good_inc;
    logic [2:0] prev, expect_code;
    logic       en_prev, prev_valid;
    logic       onehot, legal, err_inc, rev_hit;
    logic [1:0] phase_nxt;

    assign onehot      = (bus.count_in == 3'b001) || (bus.count_in == 3'b010) ||
                         (bus.count_in == 3'b100);
    assign expect_code = en_prev ? {prev[1:0], prev[2]} : prev;
    assign legal       = onehot && (!prev_valid || (bus.count_in == expect_code));
    assign good_inc    = 4'(good_cnt) + 4'd1;
    // Errors are neither counted in FAULT nor on an edge that clears the counter.
    assign err_inc     = !legal && (state != FAULT) && !bus.clear_err;
    assign rev_hit     = (state == LOCKED) && en_prev && (prev == 3'b100) &&
                         (bus.count_in == 3'b001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCK;
            good_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        unique case (state)
            UNLOCK: if (legal) begin
                state_nxt = (SYNC_LEN == 1) ? LOCKED : SYNC;
                good_nxt  = 3'd1;
            end
            SYNC: if (legal) begin
                good_nxt = good_inc[2:0];
                if (good_inc >= 4'(SYNC_LEN)) state_nxt = LOCKED;
            end else begin
                state_nxt = UNLOCK;
                good_nxt  = 3'd0;
            end
            LOCKED: if (!legal) state_nxt = FAULT;
            FAULT:  if (bus.clear_err) state_nxt = UNLOCK;
            default: state_nxt = UNLOCK;
        endcase
        if (bus.clear_err) good_nxt = 3'd0;
    end

    always_comb begin
        bus.locked = (state == LOCKED);
        bus.fault  = (state == FAULT);
    end

    always_comb begin
        unique case (bus.count_in)
            3'b001:  phase_nxt = 2'd0;
            3'b010:  phase_nxt = 2'd1;
            3'b100:  phase_nxt = 2'd2;
            default: phase_nxt = 2'd3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev          <= 3'b000;
            en_prev       <= 1'b0;
            prev_valid    <= 1'b0;
            bus.phase     <= 2'd3;
            bus.rev_count <= 8'd0;
            bus.err_count <= 4'd0;
            bus.rev_pulse <= 1'b0;
        end else begin
            prev          <= bus.count_in;
            en_prev       <= bus.enable;
            prev_valid    <= 1'b1;
            bus.phase     <= phase_nxt;
            bus.rev_pulse <= rev_hit;
            if (rev_hit) bus.rev_count <= bus.rev_count + 8'd1;
            if (bus.clear_err)
                bus.err_count <= 4'd0;
            else if (err_inc && (bus.err_count != 4'd15))
                bus.err_count <= bus.err_count + 4'd1;
        end
    end
endmodule

// File: tb/tb_iiitb_3bit_rc_mon.sv
// Directed plus randomized bench for the ring counter monitor, checked against
// a behavioural model of the monitor rules.
module tb_iiitb_3bit_rc_mon;
    localparam int SYNC_LEN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iiitb_3bit_rc_mon_if bus();
    iiitb_3bit_rc_mon #(.SYNC_LEN(SYNC_LEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nchk = 0;
    int npass = 0;

    // model state: sync progress (0 = unlocked), lock/fault flags, counters
    bit   have_prev, men_prev, mlocked, mfault, mpulse;
    int   mprev, mgood, mrev, merr, mphase;
    int   rc;

    function automatic int next_code(int c);
        return (c == 4) ? 1 : c * 2;
    endfunction

    function automatic bit is_onehot(int c);
        return (c == 1) || (c == 2) || (c == 4);
    endfunction

    task automatic model_reset();
        have_prev = 0; men_prev = 0; mprev = 0;
        mlocked = 0; mfault = 0; mpulse = 0;
        mgood = 0; mrev = 0; merr = 0; mphase = 3;
    endtask

    task automatic model_step(bit en, int cnt, bit clr);
        bit legal, err, rev;
        legal = is_onehot(cnt) &&
                (!have_prev || cnt == (men_prev ? next_code(mprev) : mprev));
        rev = mlocked && men_prev && mprev == 4 && cnt == 1;
        err = 0;
        if (mfault) begin
            if (clr) begin mfault = 0; mgood = 0; end
        end else if (mlocked) begin
            if (!legal) begin mlocked = 0; mfault = 1; err = 1; end
        end else if (legal) begin
            mgood++;
            if (mgood >= SYNC_LEN) mlocked = 1;
        end else begin
            mgood = 0; err = 1;
        end
        if (clr) begin
            merr = 0; mgood = 0;
        end else if (err && merr < 15) merr++;
        if (rev) mrev = (mrev + 1) % 256;
        mpulse = rev;
        mphase = (cnt == 1) ? 0 : (cnt == 2) ? 1 : (cnt == 4) ? 2 : 3;
        have_prev = 1; mprev = cnt; men_prev = en;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("phase",     32'(bus.phase),     32'(mphase));
        chk("locked",    32'(bus.locked),    32'(mlocked));
        chk("fault",     32'(bus.fault),     32'(mfault));
        chk("rev_count", 32'(bus.rev_count), 32'(mrev));
        chk("err_count", 32'(bus.err_count), 32'(merr));
        chk("rev_pulse", 32'(bus.rev_pulse), 32'(mpulse));
    endtask

    task automatic step(bit en, int cnt, bit clr);
        bus.enable    = en;
        bus.count_in  = 3'(cnt);
        bus.clear_err = clr;
        @(posedge clk);
        model_step(en, cnt, clr);
        @(negedge clk);
        check_all();
    endtask

    task automatic ring(int n, bit en);
        repeat (n) begin
            step(en, rc, 1'b0);
            if (en) rc = next_code(rc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2 check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r, cnt, r0, guard;
        bus.enable = 1'b0; bus.count_in = 3'b000; bus.clear_err = 1'b0;
        model_reset();
        #12 check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // lock-up from reset, phase tracking, first revolution
        rc = 1;
        ring(3, 1'b1);
        chk("lock_after_3", 32'(bus.locked), 32'd1);
        ring(1, 1'b1);
        chk("first_rev_pulse", 32'(bus.rev_pulse), 32'd1);
        chk("first_rev_count", 32'(bus.rev_count), 32'd1);

        // hold steps at 010 while locked
        ring(5, 1'b0);
        chk("hold_locked", 32'(bus.locked), 32'd1);
        chk("hold_rev", 32'(bus.rev_count), 32'd1);
        chk("hold_err", 32'(bus.err_count), 32'd0);

        // skip 001 -> 100 while locked
        ring(3, 1'b1);
        step(1'b1, 4, 1'b0);
        chk("skip_fault", 32'(bus.fault), 32'd1);
        chk("skip_err", 32'(bus.err_count), 32'd1);
        repeat (2) step(1'b1, 3, 1'b0);
        chk("fault_no_count", 32'(bus.err_count), 32'd1);
        chk("fault_phase3", 32'(bus.phase), 32'd3);

        // clear from FAULT, then relock
        step(1'b1, 1, 1'b1);
        chk("clear_fault", 32'(bus.fault), 32'd0);
        chk("clear_err", 32'(bus.err_count), 32'd0);
        rc = 2;
        ring(3, 1'b1);
        chk("relock", 32'(bus.locked), 32'd1);

        // error saturation in UNLOCK
        step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b1);
        repeat (20) step(1'b1, 0, 1'b0);
        chk("err_saturate", 32'(bus.err_count), 32'd15);
        step(1'b1, 1, 1'b1);
        rc = 2;
        ring(3, 1'b1);

        // 256 revolutions wrap the counter
        r0 = mrev;
        for (int i = 0; i < 768; i++) begin
            ring(1, 1'b1);
            if (mpulse && mrev == 0) begin
                chk("wrap_pulse", 32'(bus.rev_pulse), 32'd1);
                chk("wrap_zero", 32'(bus.rev_count), 32'd0);
            end
        end
        chk("wrap_full", 32'(bus.rev_count), 32'(r0));

        // randomized mix of legal steps, corrupt codes and clears
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                ring(1, 1'($urandom_range(0, 1)));
            end else if (r < 9) begin
                cnt = $urandom_range(0, 7);
                step(1'b1, cnt, 1'b0);
                rc = is_onehot(cnt) ? next_code(cnt) : 1;
            end else if (!mlocked) begin
                step(1'b1, rc, 1'b1);
                rc = next_code(rc);
            end else begin
                ring(1, 1'b1);
            end
        end

        // asynchronous reset mid-cycle while locked with rev_count = 37
        do_reset();
        rc = 1;
        ring(3, 1'b1);
        guard = 0;
        while (mrev != 37 && guard < 200) begin
            ring(1, 1'b1);
            guard++;
        end
        chk("rev_at_37", 32'(bus.rev_count), 32'd37);
        chk("locked_before_rst", 32'(bus.locked), 32'd1);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        rst_n = 1'b1;
        step(1'b1, 4, 1'b0);
        chk("post_rst_first_legal", 32'(bus.err_count), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
